// File: rtl/seq_det_sched_pkg.sv
// Shared definitions for the sequence-detector scheduler.
//   - state_e : scheduler FSM states (IDLE, FLUSH, SHIFT, DRAIN, DONE)
//   - STATE_W : state encoding width
//   - *_DEF   : default NREQ / WORD_W / CNT_W
// Optional feature macro (used by the files that import this package):
//   SEQ_DET_SCHED_RR_EN  defined   -> round-robin arbitration
//                        undefined -> fixed priority, lowest index wins
package seq_det_sched_pkg;

  localparam int STATE_W    = 3;
  localparam int NREQ_DEF   = 4;
  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_det_rr_arb.sv
// Combinational winner select for the sequence-detector scheduler.
// Ports:
//   req_i     : per-requester request bits
//   last_id_i : id served last; search starts at last_id_i+1 (only with
//               SEQ_DET_SCHED_RR_EN defined)
//   gnt_o     : one-hot winner (all zero when no request)
//   id_o      : binary id of the winner (0 when no request)
// Macro SEQ_DET_SCHED_RR_EN selects round-robin; otherwise fixed priority
// with the lowest index winning.
import seq_det_sched_pkg::*;

module seq_det_rr_arb #(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifdef SEQ_DET_SCHED_RR_EN
  input  logic [ID_W-1:0] last_id_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] id_o
);

  int   idx;
  logic found;

`ifdef SEQ_DET_SCHED_RR_EN
  // Walk the ring starting just after the last served requester.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    idx   = 0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_id_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = k;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = ID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/seq_det_sched.sv
// Scheduler sharing one serial Moore sequence detector among NREQ
// requesters. A granted word is shifted MSB-first into the detector after a
// one-cycle detector flush; detector hits are counted (saturating) and
// returned with a done pulse tagged by requester id.
// Ports:
//   clk_i       : clock, rising edge
//   rst_ni      : synchronous active-low reset
//   req_i       : per-requester level requests
//   data_i      : flattened words, requester i at [i*WORD_W +: WORD_W]
//   grant_o     : one-hot grant, held FLUSH..DRAIN
//   busy_o      : high outside IDLE
//   done_o      : one-cycle result pulse
//   done_id_o   : finished requester id, valid with done_o
//   match_cnt_o : saturated hit count, valid with done_o
//   det_in_o    : serial bit to detector
//   det_rst_o   : active-high detector reset (IDLE and FLUSH)
//   det_out_i   : detector Moore output
// Macro SEQ_DET_SCHED_RR_EN: round-robin arbitration when defined, fixed
// priority (lowest index) otherwise.
import seq_det_sched_pkg::*;

module seq_det_sched #(
  parameter int NREQ   = NREQ_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*WORD_W-1:0] data_i,
  output logic [NREQ-1:0]        grant_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ID_W-1:0]        done_id_o,
  output logic [CNT_W-1:0]       match_cnt_o,
  output logic                   det_in_o,
  output logic                   det_rst_o,
  input  logic                   det_out_i
);

  localparam int BC_W = $clog2(WORD_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;
  logic              done_q;
  logic [ID_W-1:0]   done_id_q;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              det_in_q;
  logic              det_rst_q;
  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-1:0] word_d;
  logic [BC_W-1:0]   bitcnt_q;
  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_id;

`ifdef SEQ_DET_SCHED_RR_EN
  logic [ID_W-1:0]   last_id_q;
`endif

  seq_det_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i     (req_i),
`ifdef SEQ_DET_SCHED_RR_EN
    .last_id_i (last_id_q),
`endif
    .gnt_o     (arb_gnt),
    .id_o      (arb_id)
  );

  assign word_d = data_i[int'(arb_id)*WORD_W +: WORD_W];
  assign cnt_d  = det_out_i ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      det_in_q  <= 1'b0;
      det_rst_q <= 1'b1;
      bitcnt_q  <= '0;
`ifdef SEQ_DET_SCHED_RR_EN
      last_id_q <= ID_W'(NREQ-1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          det_rst_q <= 1'b1;
          if (|req_i) begin
            grant_q <= arb_gnt;
            id_q    <= arb_id;
            sreg_q  <= word_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          det_rst_q <= 1'b0;
          det_in_q  <= sreg_q[WORD_W-1];
          sreg_q    <= {sreg_q[WORD_W-2:0], 1'b0};
          bitcnt_q  <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          // det_out lags det_in by one cycle, so the first SHIFT cycle
          // still shows the flushed detector and is not counted.
          if (bitcnt_q != '0) cnt_q <= cnt_d;
          if (bitcnt_q == BC_W'(WORD_W-1)) begin
            det_in_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            det_in_q <= sreg_q[WORD_W-1];
            sreg_q   <= {sreg_q[WORD_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
        DRAIN: begin
          cnt_q     <= cnt_d;
          done_q    <= 1'b1;
          done_id_q <= id_q;
          grant_q   <= '0;
          state_q   <= DONE;
        end
        DONE: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          det_rst_q <= 1'b1;
`ifdef SEQ_DET_SCHED_RR_EN
          last_id_q <= id_q;
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;
  assign match_cnt_o = cnt_q;
  assign det_in_o    = det_in_q;
  assign det_rst_o   = det_rst_q;

endmodule
